// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and types for uart_receive and uart_rx_fifo
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;
  localparam int UART_RX_FIFO_AW    = $clog2(UART_RX_FIFO_DEPTH);

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x byte storage, one synchronous write port, one combinational read port
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int AW    = UART_RX_FIFO_AW
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  uart_byte_t mem [DEPTH];

  // Contents are deliberately never reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO, FWFT; threshold irq under UART_RX_FIFO_THRESH_IRQ_EN
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int AW    = UART_RX_FIFO_AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   empty,
  output logic [AW:0]            count,
  input  logic                   flush,
  output logic                   overrun,
  input  logic                   clr_overrun,
  input  logic [AW:0]            thresh,
  output logic                   irq_thresh
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   wr_acc;
  logic                   rd_acc;
  logic                   drop;
  logic                   mem_we;
  logic [UART_DATA_W-1:0] mem_rdata;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A write into a full FIFO still lands when a read frees the head slot in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_en);
  assign drop   = wr_en & full & ~rd_en & ~flush;
  assign mem_we = wr_acc & ~flush & rst_n;

  uart_fifo_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(rd_ptr),
    .rdata(mem_rdata)
  );

  assign rd_data = empty ? '0 : mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Set has priority over clear so a lost byte is never silently forgotten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_thresh <= 1'b0;
    end else begin
      irq_thresh <= (thresh != '0) && (count >= thresh);
    end
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign irq_thresh    = 1'b0;
`endif

endmodule
